// File: rtl/rv_defs.sv
// Shared definitions for the data-memory path: load/store function codes,
// sequencer states and byte-select constants.
package rv_defs;

    // Load/store width codes (funct3-style): bit 2 = unsigned, [1:0] = size
    localparam logic [2:0] LDST_B  = 3'b000;
    localparam logic [2:0] LDST_H  = 3'b001;
    localparam logic [2:0] LDST_L  = 3'b010;
    localparam logic [2:0] LDST_BU = 3'b100;
    localparam logic [2:0] LDST_HU = 3'b101;

    typedef enum logic [1:0] {
        StIdle,
        StLoadWait,
        StStoreWait,
        StResp
    } dm_state_e;

    localparam logic [3:0] DM_SEL_B0 = 4'b0001;
    localparam logic [3:0] DM_SEL_H0 = 4'b0011;
    localparam logic [3:0] DM_SEL_H1 = 4'b1100;
    localparam logic [3:0] DM_SEL_W  = 4'b1111;

endpackage

// File: rtl/rv_dm_lane_gen.sv
// Combinational byte-lane generator: byte enables, lane-replicated store data
// and misalignment flag from access width and low address bits.
module rv_dm_lane_gen
    import rv_defs::*;
(
    input  logic [2:0]  i_fun,
    input  logic [1:0]  i_addr,
    input  logic [31:0] i_wdata,
    output logic [3:0]  o_sel,
    output logic [31:0] o_data,
    output logic        o_misaligned
);

    always_comb begin
        o_sel        = DM_SEL_W;
        o_data       = i_wdata;
        o_misaligned = 1'b0;
        case (i_fun)
            LDST_B, LDST_BU: begin
                o_sel  = DM_SEL_B0 << i_addr;
                o_data = {4{i_wdata[7:0]}};
            end
            LDST_H, LDST_HU: begin
                o_sel        = i_addr[1] ? DM_SEL_H1 : DM_SEL_H0;
                o_data       = {2{i_wdata[15:0]}};
                o_misaligned = i_addr[0];
            end
            // Word and any unassigned code are treated as a full-word access
            default: o_misaligned = |i_addr;
        endcase
    end

endmodule

// File: rtl/rv_dm_ctrl.sv
// Data-memory access sequencer: issues one load/store per request, waits for
// bus completion or timeout, and hands raw load data to writeback.
module rv_dm_ctrl
    import rv_defs::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_WIDTH      = 16
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        x_req_i,
    input  logic        x_load_i,
    input  logic [2:0]  x_fun_i,
    input  logic [31:0] x_addr_i,
    input  logic [31:0] x_wdata_i,
    input  logic        w_stall_i,
    output logic [31:0] dm_addr_o,
    output logic [31:0] dm_data_s_o,
    output logic [3:0]  dm_sel_o,
    output logic        dm_load_o,
    output logic        dm_store_o,
    input  logic [31:0] dm_data_l_i,
    input  logic        dm_load_done_i,
    input  logic        dm_store_done_i,
    output logic [31:0] dm_data_l_o,
    output logic        dm_valid_l_o,
    output logic        stall_req_o,
    output logic        exc_misaligned_o,
    output logic        exc_bus_err_o
);

    localparam logic [CNT_WIDTH-1:0] TIMEOUT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    dm_state_e            r_state, w_state_nxt;
    logic [CNT_WIDTH-1:0] r_cnt, w_cnt_nxt;
    logic [29:0]          r_addr;
    logic [3:0]           r_sel;
    logic [31:0]          r_wdata;
    logic [31:0]          r_rdata;
    logic                 r_exc_mis;
    logic                 r_exc_bus;

    logic [3:0]  w_sel;
    logic [31:0] w_data;
    logic        w_mis;
    logic        w_accept;
    logic        w_capture;
    logic        w_mis_pulse;
    logic        w_bus_err;

    rv_dm_lane_gen u_lane_gen (
        .i_fun        (x_fun_i),
        .i_addr       (x_addr_i[1:0]),
        .i_wdata      (x_wdata_i),
        .o_sel        (w_sel),
        .o_data       (w_data),
        .o_misaligned (w_mis)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        w_capture   = 1'b0;
        w_mis_pulse = 1'b0;
        w_bus_err   = 1'b0;
        case (r_state)
            StIdle: begin
                if (x_req_i) begin
                    if (w_mis) begin
                        w_mis_pulse = 1'b1;
                    end else begin
                        w_accept    = 1'b1;
                        w_cnt_nxt   = '0;
                        w_state_nxt = x_load_i ? StLoadWait : StStoreWait;
                    end
                end
            end
            StLoadWait: begin
                // Completion has priority over a timeout in the same cycle
                if (dm_load_done_i) begin
                    w_capture   = 1'b1;
                    w_state_nxt = StResp;
                end else if (r_cnt == TIMEOUT_LAST) begin
                    w_bus_err   = 1'b1;
                    w_state_nxt = StIdle;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_WIDTH'(1);
                end
            end
            StStoreWait: begin
                if (dm_store_done_i) begin
                    w_state_nxt = StIdle;
                end else if (r_cnt == TIMEOUT_LAST) begin
                    w_bus_err   = 1'b1;
                    w_state_nxt = StIdle;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_WIDTH'(1);
                end
            end
            StResp: begin
                if (!w_stall_i) begin
                    w_state_nxt = StIdle;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state   <= StIdle;
            r_cnt     <= '0;
            r_addr    <= '0;
            r_sel     <= '0;
            r_wdata   <= '0;
            r_rdata   <= '0;
            r_exc_mis <= 1'b0;
            r_exc_bus <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_exc_mis <= w_mis_pulse;
            r_exc_bus <= w_bus_err;
            if (w_accept) begin
                r_addr  <= x_addr_i[31:2];
                r_sel   <= w_sel;
                r_wdata <= w_data;
            end
            if (w_capture) begin
                r_rdata <= dm_data_l_i;
            end
        end
    end

    assign dm_addr_o        = {r_addr, 2'b00};
    assign dm_data_s_o      = r_wdata;
    assign dm_sel_o         = r_sel;
    assign dm_load_o        = (r_state == StLoadWait);
    assign dm_store_o       = (r_state == StStoreWait);
    assign dm_data_l_o      = r_rdata;
    assign dm_valid_l_o     = (r_state == StResp);
    assign exc_misaligned_o = r_exc_mis;
    assign exc_bus_err_o    = r_exc_bus;
    assign stall_req_o      = ((r_state == StIdle) && x_req_i && !w_mis)
                              || dm_load_o || dm_store_o;

endmodule

// File: tb/tb_rv_dm_ctrl.sv
// Self-checking bench for rv_dm_ctrl: directed vector table, reset-in-access
// sequence and randomized accesses checked against a width/offset model.
module tb_rv_dm_ctrl;
    import rv_defs::*;

    localparam int unsigned TIMEOUT = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        x_req, x_load, w_stall;
    logic [2:0]  x_fun;
    logic [31:0] x_addr, x_wdata, bus_rdata;
    logic        ld_done, st_done;
    logic [31:0] dm_addr, dm_data_s, dm_data_l;
    logic [3:0]  dm_sel;
    logic        dm_load, dm_store, dm_valid, stall_req, exc_mis, exc_bus;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    rv_dm_ctrl #(
        .TIMEOUT_CYCLES (TIMEOUT),
        .CNT_WIDTH      (16)
    ) dut (
        .clk_i            (clk),
        .rst_n_i          (rst_n),
        .x_req_i          (x_req),
        .x_load_i         (x_load),
        .x_fun_i          (x_fun),
        .x_addr_i         (x_addr),
        .x_wdata_i        (x_wdata),
        .w_stall_i        (w_stall),
        .dm_addr_o        (dm_addr),
        .dm_data_s_o      (dm_data_s),
        .dm_sel_o         (dm_sel),
        .dm_load_o        (dm_load),
        .dm_store_o       (dm_store),
        .dm_data_l_i      (bus_rdata),
        .dm_load_done_i   (ld_done),
        .dm_store_done_i  (st_done),
        .dm_data_l_o      (dm_data_l),
        .dm_valid_l_o     (dm_valid),
        .stall_req_o      (stall_req),
        .exc_misaligned_o (exc_mis),
        .exc_bus_err_o    (exc_bus)
    );

    typedef struct {
        logic [2:0]  fun;
        logic        ld;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          delay;  // strobe cycle index carrying done; >= TIMEOUT means never
        int          stall;  // writeback stall cycles in RESP
        logic [3:0]  sel;
        logic [31:0] sdata;
        logic        mis;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        check(name, 32'(act), 32'(exp));
    endtask

    // Reference model: access size in bytes and lane arithmetic
    function automatic int size_of(input logic [2:0] fun);
        if (fun == LDST_B || fun == LDST_BU) return 1;
        if (fun == LDST_H || fun == LDST_HU) return 2;
        return 4;
    endfunction

    function automatic logic model_mis(input logic [2:0] fun, input logic [31:0] addr);
        return (addr % size_of(fun)) != 0;
    endfunction

    function automatic logic [3:0] model_sel(input logic [2:0] fun, input logic [31:0] addr);
        logic [3:0] s = '0;
        int off = int'(addr % 4);
        for (int i = 0; i < size_of(fun); i++)
            if (off + i < 4) s[off + i] = 1'b1;
        return s;
    endfunction

    function automatic logic [31:0] model_sdata(input logic [2:0] fun, input logic [31:0] wdata);
        logic [31:0] d;
        for (int b = 0; b < 4; b++)
            d[8*b +: 8] = wdata[8*(b % size_of(fun)) +: 8];
        return d;
    endfunction

    task automatic run_txn(input vec_t v, input string tag);
        bit tmo;
        int n_strobe;
        tmo = (v.delay >= int'(TIMEOUT));
        n_strobe = tmo ? int'(TIMEOUT) : v.delay + 1;
        @(negedge clk);
        x_req = 1'b1; x_load = v.ld; x_fun = v.fun; x_addr = v.addr; x_wdata = v.wdata;
        #1;
        chk1({tag, ":req_stall"}, stall_req, !v.mis);
        chk1({tag, ":req_nostrobe"}, dm_load | dm_store, 1'b0);
        @(negedge clk);
        x_req = 1'b0; x_addr = $urandom; x_wdata = $urandom; x_fun = 3'($urandom);
        if (v.mis) begin
            #1;
            chk1({tag, ":mis_pulse"}, exc_mis, 1'b1);
            chk1({tag, ":mis_nostrobe"}, dm_load | dm_store, 1'b0);
            chk1({tag, ":mis_stall"}, stall_req, 1'b0);
            @(negedge clk); #1;
            chk1({tag, ":mis_end"}, exc_mis, 1'b0);
            chk1({tag, ":mis_idle"}, dm_load | dm_store | dm_valid, 1'b0);
            return;
        end
        for (int k = 0; k < n_strobe; k++) begin
            if (k > 0) @(negedge clk);
            x_req     = 1'($urandom);
            bus_rdata = (k == v.delay) ? v.rdata : $urandom;
            ld_done   = v.ld && (k == v.delay);
            st_done   = !v.ld && (k == v.delay);
            #1;
            chk1({tag, ":load"}, dm_load, v.ld);
            chk1({tag, ":store"}, dm_store, !v.ld);
            check({tag, ":addr"}, dm_addr, v.addr & 32'hFFFF_FFFC);
            check({tag, ":sel"}, 32'(dm_sel), 32'(v.sel));
            if (!v.ld) check({tag, ":sdata"}, dm_data_s, v.sdata);
            chk1({tag, ":wait_stall"}, stall_req, 1'b1);
            chk1({tag, ":wait_valid"}, dm_valid | exc_bus, 1'b0);
        end
        @(negedge clk);
        ld_done = 1'b0; st_done = 1'b0; x_req = 1'b0;
        if (tmo) begin
            // Late done pulses must be ignored once the access is aborted
            ld_done = 1'b1; st_done = 1'b1;
            #1;
            chk1({tag, ":buserr"}, exc_bus, 1'b1);
            chk1({tag, ":tmo_nostrobe"}, dm_load | dm_store, 1'b0);
            chk1({tag, ":tmo_novalid"}, dm_valid, 1'b0);
            chk1({tag, ":tmo_stall"}, stall_req, 1'b0);
            @(negedge clk); #1;
            chk1({tag, ":buserr_end"}, exc_bus, 1'b0);
            chk1({tag, ":late_done"}, dm_valid | dm_load | dm_store, 1'b0);
            @(negedge clk);
            ld_done = 1'b0; st_done = 1'b0;
        end else if (v.ld) begin
            for (int s = 0; s <= v.stall; s++) begin
                if (s > 0) @(negedge clk);
                w_stall = (s < v.stall);
                x_req = 1'($urandom); bus_rdata = $urandom;
                #1;
                chk1({tag, ":valid"}, dm_valid, 1'b1);
                check({tag, ":rdata"}, dm_data_l, v.rdata);
                chk1({tag, ":resp_stall"}, stall_req, 1'b0);
                chk1({tag, ":resp_nostrobe"}, dm_load, 1'b0);
            end
            @(negedge clk);
            x_req = 1'b0; w_stall = 1'($urandom);
            #1;
            chk1({tag, ":valid_end"}, dm_valid, 1'b0);
        end else begin
            #1;
            chk1({tag, ":st_end"}, dm_store, 1'b0);
            chk1({tag, ":st_novalid"}, dm_valid | exc_bus, 1'b0);
        end
        w_stall = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        rst_n = 1'b0; x_req = 1'b0; x_load = 1'b0; x_fun = '0; x_addr = '0; x_wdata = '0;
        w_stall = 1'b0; bus_rdata = '0; ld_done = 1'b0; st_done = 1'b0;

        vecs[0]  = '{LDST_L,  1'b1, 32'h100,  32'h1234_5678, 32'hDEAD_BEEF, 0, 0, 4'b1111,
                     32'h1234_5678, 1'b0};
        vecs[1]  = '{LDST_B,  1'b0, 32'h203,  32'h0000_00A5, 32'h0, 2, 0, 4'b1000,
                     32'hA5A5_A5A5, 1'b0};
        vecs[2]  = '{LDST_H,  1'b1, 32'h101,  32'h0, 32'h0, 0, 0, 4'b0000, 32'h0, 1'b1};
        vecs[3]  = '{LDST_BU, 1'b1, 32'h12,   32'h0, 32'h1122_3344, 1, 2, 4'b0100,
                     32'h0, 1'b0};
        vecs[4]  = '{LDST_L,  1'b1, 32'h40,   32'h0, 32'hFFFF_0000, 9, 0, 4'b1111,
                     32'h0, 1'b0};
        vecs[5]  = '{LDST_L,  1'b0, 32'h44,   32'hCAFE_F00D, 32'h0, 3, 0, 4'b1111,
                     32'hCAFE_F00D, 1'b0};
        vecs[6]  = '{LDST_H,  1'b0, 32'h1006, 32'hCAFE_BEEF, 32'h0, 1, 0, 4'b1100,
                     32'hBEEF_BEEF, 1'b0};
        vecs[7]  = '{LDST_L,  1'b0, 32'h12,   32'h0, 32'h0, 0, 0, 4'b0000, 32'h0, 1'b1};
        vecs[8]  = '{LDST_HU, 1'b1, 32'h2,    32'h0, 32'h89AB_CDEF, 0, 1, 4'b1100,
                     32'h0, 1'b0};
        vecs[9]  = '{LDST_B,  1'b0, 32'h1,    32'h1234_5677, 32'h0, 0, 0, 4'b0010,
                     32'h7777_7777, 1'b0};
        vecs[10] = '{LDST_L,  1'b0, 32'h88,   32'h0BAD_F00D, 32'h0, 5, 0, 4'b1111,
                     32'h0BAD_F00D, 1'b0};

        #1;
        chk1("rst_strobes", dm_load | dm_store, 1'b0);
        check("rst_addr", dm_addr, 32'h0);
        check("rst_sel", 32'(dm_sel), 32'h0);
        check("rst_data", dm_data_l, 32'h0);
        chk1("rst_flags", dm_valid | stall_req | exc_mis | exc_bus, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) run_txn(vecs[i], $sformatf("vec%0d", i));

        // Asynchronous reset while a store is waiting on the bus
        @(negedge clk);
        x_req = 1'b1; x_load = 1'b0; x_fun = LDST_L; x_addr = 32'h300; x_wdata = 32'h5555_AAAA;
        @(negedge clk);
        x_req = 1'b0;
        #1 chk1("arst_store_on", dm_store, 1'b1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk1("arst_store_off", dm_store, 1'b0);
        check("arst_addr", dm_addr, 32'h0);
        check("arst_sdata", dm_data_s, 32'h0);
        chk1("arst_flags", dm_valid | stall_req | exc_mis | exc_bus | dm_load, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        run_txn(vecs[0], "post_rst");

        for (int n = 0; n < 40; n++) begin
            logic [2:0] funs [5];
            funs = '{LDST_B, LDST_BU, LDST_H, LDST_HU, LDST_L};
            v.fun   = funs[$urandom_range(0, 4)];
            v.ld    = 1'($urandom);
            v.addr  = $urandom;
            if ($urandom_range(0, 2) != 0) v.addr = v.addr - (v.addr % size_of(v.fun));
            v.wdata = $urandom;
            v.rdata = $urandom;
            v.delay = $urandom_range(0, 5);
            v.stall = $urandom_range(0, 2);
            v.mis   = model_mis(v.fun, v.addr);
            v.sel   = model_sel(v.fun, v.addr);
            v.sdata = model_sdata(v.fun, v.wdata);
            run_txn(v, $sformatf("rnd%0d", n));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
